// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// parity helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_A   = 7;
    localparam int unsigned SAMPLE_B   = 8;
    localparam int unsigned SAMPLE_C   = 9;
    localparam int unsigned FRAME_BITS = 11;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic calc_parity(input logic [7:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detect on the synchronized value.
module uart_rx_sync (
    input  logic result_clock_to_sample,
    input  logic reset,
    input  logic i_rx,
    output logic o_rxs,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Flops preset to the idle-high line level so reset release never looks like an edge.
    always_ff @(posedge result_clock_to_sample or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rxs  = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, DATA_BITS data bits LSB first, even
// parity, one stop bit; 2-of-3 majority vote at the middle of every bit.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 result_clock_to_sample,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic                 Rx_D,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_BUSY
);

    import uart_pkg::*;

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_A    = CNT_W'(SAMPLE_A);
    localparam logic [CNT_W-1:0] CNT_B    = CNT_W'(SAMPLE_B);
    localparam logic [CNT_W-1:0] CNT_C    = CNT_W'(SAMPLE_C);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s_a;
    logic                 r_s_b;
    logic                 r_perr_pend;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;

    logic w_rxs;
    logic w_fall;
    logic w_bit;
    logic w_at_c;
    logic w_at_end;
    logic w_finish;

    uart_rx_sync u_sync (
        .result_clock_to_sample (result_clock_to_sample),
        .reset                  (reset),
        .i_rx                   (Rx_D),
        .o_rxs                  (w_rxs),
        .o_fall                 (w_fall)
    );

    assign w_at_c   = (r_cnt == CNT_C);
    assign w_at_end = (r_cnt == CNT_LAST);
    // Majority of the two stored mid-bit samples and the current one.
    assign w_bit    = (r_s_a & r_s_b) | (r_s_a & w_rxs) | (r_s_b & w_rxs);

    always_comb begin
        w_state_next = r_state;
        w_finish     = 1'b0;
        if (!Rx_EN) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fall) w_state_next = ST_START;
                end
                ST_START: begin
                    if (w_at_c && w_bit) w_state_next = ST_IDLE;
                    else if (w_at_end)   w_state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (w_at_end && (r_idx == IDX_LAST)) w_state_next = ST_PARITY;
                end
                ST_PARITY: begin
                    if (w_at_end) w_state_next = ST_STOP;
                end
                ST_STOP: begin
                    if (w_at_c) begin
                        w_state_next = ST_IDLE;
                        w_finish     = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Counter sits at zero in IDLE and restarts on every state entry.
    assign w_cnt_next = ((w_state_next != r_state) || (r_state == ST_IDLE))
                        ? '0 : r_cnt + 1'b1;

    always_ff @(posedge result_clock_to_sample or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_s_a       <= 1'b0;
            r_s_b       <= 1'b0;
            r_perr_pend <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_valid <= 1'b0;
            if (r_cnt == CNT_A) r_s_a <= w_rxs;
            if (r_cnt == CNT_B) r_s_b <= w_rxs;
            if (r_state == ST_START) r_idx <= '0;
            if (Rx_EN && (r_state == ST_DATA)) begin
                if (w_at_c)   r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                if (w_at_end) r_idx   <= r_idx + 1'b1;
            end
            if (Rx_EN && (r_state == ST_PARITY) && w_at_c)
                r_perr_pend <= (w_bit != calc_parity(r_shift));
            if (w_finish) begin
                r_perr <= r_perr_pend;
                r_ferr <= ~w_bit;
                if (!r_perr_pend && w_bit) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign Rx_DATA   = r_data;
    assign Rx_VALID  = r_valid;
    assign Rx_PERROR = r_perr;
    assign Rx_FERROR = r_ferr;
    assign Rx_BUSY   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, hand-written
// corner sequences and randomized frames against a frame-level reference model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_EN;
    logic       Rx_D;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    int unsigned checks   = 0;
    int unsigned errors   = 0;
    int unsigned cyc      = 0;
    int unsigned busy_cnt = 0;
    int unsigned vq_cyc[$];
    logic [7:0]  vq_dat[$];

    // Line change -> next edge (1) -> two sync flops (2) -> start edge T0, then T0+170.
    localparam int unsigned LAT = 1 + 2 + 170;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         gap;
        int         abort_bit;
        int         abort_kind;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t tv[10];

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .result_clock_to_sample (clk),
        .reset                  (reset),
        .Rx_EN                  (Rx_EN),
        .Rx_D                   (Rx_D),
        .Rx_DATA                (Rx_DATA),
        .Rx_VALID               (Rx_VALID),
        .Rx_PERROR              (Rx_PERROR),
        .Rx_FERROR              (Rx_FERROR),
        .Rx_BUSY                (Rx_BUSY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Rx_VALID) begin
            vq_cyc.push_back(cyc);
            vq_dat.push_back(Rx_DATA);
        end
        if (Rx_BUSY) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one 11-bit frame; optionally drops Rx_EN (kind 0) or raises reset
    // (kind 1) 5 ticks into frame bit abort_bit and holds it to the frame end.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int abort_bit, input int abort_kind,
                              output int unsigned c0);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        c0 = cyc;
        for (int b = 0; b < 11; b++) begin
            Rx_D = bits[b];
            if (b == abort_bit) begin
                repeat (5) tick();
                if (abort_kind == 0) Rx_EN = 1'b0;
                else                 reset = 1'b1;
                tick();
                check("abort_busy", Rx_BUSY, 0);
                repeat (10) tick();
            end else begin
                repeat (16) tick();
            end
        end
    endtask

    task automatic check_frame(input string name, input int unsigned c0, input logic exp_valid,
                               input logic [7:0] exp_data, input logic exp_perr,
                               input logic exp_ferr);
        check({name, "_vcount"}, vq_cyc.size(), exp_valid ? 1 : 0);
        if (exp_valid && vq_cyc.size() > 0) begin
            check({name, "_latency"}, vq_cyc[0] - c0, LAT);
            check({name, "_vdata"}, vq_dat[0], exp_data);
        end
        check({name, "_data"}, Rx_DATA, exp_data);
        check({name, "_perr"}, Rx_PERROR, exp_perr);
        check({name, "_ferr"}, Rx_FERROR, exp_ferr);
    endtask

    initial begin
        int unsigned c0;
        logic [7:0]  m_data;
        logic        m_perr;
        logic        m_ferr;
        logic        prev_stop_low;

        //            data   par   stop gap abort kind valid data   perr  ferr
        tv[0] = '{8'hA5, 1'b0, 1'b1, 20, -1, 0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tv[1] = '{8'h07, 1'b0, 1'b1, 10, -1, 0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tv[2] = '{8'h3C, 1'b0, 1'b0, 10, -1, 0, 1'b0, 8'hA5, 1'b0, 1'b1};
        tv[3] = '{8'h55, 1'b0, 1'b1,  8, -1, 0, 1'b1, 8'h55, 1'b0, 1'b0};
        tv[4] = '{8'h01, 1'b1, 1'b1, 10, -1, 0, 1'b1, 8'h01, 1'b0, 1'b0};
        tv[5] = '{8'hFE, 1'b1, 1'b1,  0, -1, 0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tv[6] = '{8'h99, 1'b0, 1'b1, 10,  5, 0, 1'b0, 8'hFE, 1'b0, 1'b0};
        tv[7] = '{8'h42, 1'b0, 1'b1,  8, -1, 0, 1'b1, 8'h42, 1'b0, 1'b0};
        tv[8] = '{8'h99, 1'b0, 1'b1, 10,  5, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[9] = '{8'h42, 1'b0, 1'b1,  8, -1, 0, 1'b1, 8'h42, 1'b0, 1'b0};

        reset = 1'b1;
        Rx_EN = 1'b1;
        Rx_D  = 1'b1;
        repeat (3) tick();
        check("rst_data", Rx_DATA, 8'h00);
        check("rst_valid", Rx_VALID, 0);
        check("rst_perr", Rx_PERROR, 0);
        check("rst_ferr", Rx_FERROR, 0);
        check("rst_busy", Rx_BUSY, 0);
        reset = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 10; i++) begin
            Rx_D = 1'b1;
            repeat (tv[i].gap) tick();
            vq_cyc.delete();
            vq_dat.delete();
            send_frame(tv[i].data, tv[i].par, tv[i].stop, tv[i].abort_bit, tv[i].abort_kind, c0);
            Rx_EN = 1'b1;
            reset = 1'b0;
            check_frame($sformatf("vec%0d", i), c0, tv[i].exp_valid, tv[i].exp_data,
                        tv[i].exp_perr, tv[i].exp_ferr);
        end
        m_data = tv[9].exp_data;
        m_perr = tv[9].exp_perr;
        m_ferr = tv[9].exp_ferr;

        // Short low glitch on an idle line: false start, busy for exactly 10 ticks.
        Rx_D = 1'b1;
        repeat (20) tick();
        vq_cyc.delete();
        vq_dat.delete();
        busy_cnt = 0;
        Rx_D = 1'b0;
        repeat (4) tick();
        Rx_D = 1'b1;
        repeat (30) tick();
        check("glitch_busy_ticks", busy_cnt, 10);
        check_frame("glitch", 0, 1'b0, m_data, m_perr, m_ferr);

        // Break: one framing error, then no restart while the line stays low.
        vq_cyc.delete();
        vq_dat.delete();
        send_frame(8'h00, 1'b0, 1'b0, -1, 0, c0);
        repeat (60) tick();
        check("break_busy", Rx_BUSY, 0);
        check_frame("break", c0, 1'b0, m_data, 1'b0, 1'b1);
        Rx_D = 1'b1;
        repeat (16) tick();
        vq_cyc.delete();
        vq_dat.delete();
        send_frame(8'h5A, 1'b0, 1'b1, -1, 0, c0);
        m_data = 8'h5A;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        check_frame("after_break", c0, 1'b1, m_data, m_perr, m_ferr);

        // Enable rising while the line is already low must not start a frame.
        Rx_EN = 1'b0;
        repeat (8) tick();
        vq_cyc.delete();
        vq_dat.delete();
        busy_cnt = 0;
        Rx_D = 1'b0;
        repeat (16 * 4 + 5) tick();
        Rx_EN = 1'b1;
        repeat (16 * 6 - 5) tick();
        Rx_D = 1'b1;
        repeat (32) tick();
        check("en_rise_busy_ticks", busy_cnt, 0);
        check_frame("en_rise", 0, 1'b0, m_data, m_perr, m_ferr);

        // Randomized frames against the frame-level model.
        prev_stop_low = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  d;
            logic        p;
            logic        s;
            logic        good_par;
            logic        exp_v;
            int unsigned err;
            int unsigned gap;
            d        = 8'($urandom);
            err      = $urandom_range(0, 3);
            good_par = ($countones(d) % 2) == 1;
            p        = good_par ^ (err == 1);
            s        = (err != 2);
            gap      = prev_stop_low ? $urandom_range(1, 20) : $urandom_range(0, 20);
            Rx_D = 1'b1;
            repeat (gap) tick();
            vq_cyc.delete();
            vq_dat.delete();
            send_frame(d, p, s, -1, 0, c0);
            m_perr = (p != good_par);
            m_ferr = !s;
            exp_v  = !m_perr && !m_ferr;
            if (exp_v) m_data = d;
            check_frame($sformatf("rnd%0d", n), c0, exp_v, m_data, m_perr, m_ferr);
            prev_stop_low = !s;
        end

        Rx_D = 1'b1;
        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, SHALL set the number of result_clock_to_sample ticks per serial bit.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame.
REQ-003 result_clock_to_sample  input  1  SHALL be the clock, a 16x-baud tick; every register updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Rx_EN  input  1  SHALL enable reception when high.
REQ-006 Rx_D  input  1  SHALL be the serial line input, asynchronous, idle high.
REQ-007 Rx_DATA  output  8  SHALL hold the last error-free received byte.
REQ-008 Rx_VALID  output  1  SHALL pulse high for one tick when Rx_DATA is updated.
REQ-009 Rx_PERROR  output  1  SHALL flag a parity mismatch in the last completed frame.
REQ-010 Rx_FERROR  output  1  SHALL flag a framing error (stop bit low) in the last completed frame.
REQ-011 Rx_BUSY  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-012 Frame format SHALL be: start bit 0, 8 data bits LSB first, parity bit equal to the XOR of the 8 data bits (even parity), stop bit 1; 11 bits in total.
REQ-013 Rx_D SHALL pass through a 2-flop synchronizer; all decisions in REQ-014 to REQ-025 use the synchronized line (rxs).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-015 A 4-bit tick counter SHALL run 0..15 within each bit, wrap 15->0, and clear on every state entry.
REQ-016 IDLE->START SHALL occur on the first tick where rxs is 0 and the previous rxs was 1; the counter is 0 on that tick.
REQ-017 In each bit period, rxs SHALL be sampled at counts 7, 8 and 9; the bit value is the 2-of-3 majority, decided at count 9.
REQ-018 START: if the majority is 1, the FSM SHALL return to IDLE at count 9 as a false start with no output change; otherwise it SHALL go to DATA at count 15.
REQ-019 DATA: the decided bit SHALL shift into a shift register, LSB first; a 3-bit bit index advances at count 15, and the FSM goes to PARITY after index 7.
REQ-020 PARITY: the decided bit SHALL be compared with the XOR of the shifted data; the FSM goes to STOP at count 15.
REQ-021 STOP: at count 9 the FSM SHALL return to IDLE, so a new start edge can be detected half a bit early.
REQ-022 At the STOP count-9 decision, Rx_PERROR and Rx_FERROR SHALL both be updated from the current frame.
REQ-023 At the STOP count-9 decision, if neither error is set, Rx_DATA SHALL be loaded and Rx_VALID asserted on the following tick for exactly one tick.
REQ-024 On an errored frame, Rx_DATA SHALL keep its old value and Rx_VALID SHALL stay low.
REQ-025 Error flags SHALL hold until the next frame completes or reset.
REQ-026 Latency SHALL be fixed: with the start edge on tick T0, Rx_VALID is high on tick T0+170 (10*16 + 9 + 1).
REQ-027 Rx_EN low SHALL force the FSM to IDLE on the next tick, abort any frame in progress, and leave the output registers unchanged.
REQ-028 Rx_EN rising mid-frame SHALL not start reception until a new high-to-low edge is seen.
REQ-029 A line held low (break) SHALL produce one frame with Rx_FERROR=1; the FSM then waits in IDLE for rxs to return to 1 before accepting a new edge.

Reset
REQ-030 While reset is high: FSM=IDLE, counters=0, shift register=0, synchronizer flops=1, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, Rx_BUSY=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame, with no Rx_VALID pulse after release.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE, the sample points (7/8/9), FRAME_BITS=11 and the parity function, shared with the transmitter.
REQ-033 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer and the falling-edge detect; all other logic SHALL live in uart_receiver.

Verification
REQ-034 Frame 0xA5, parity 0, stop 1 -> Rx_DATA=8'hA5, Rx_VALID for 1 tick at T0+170, both errors 0.
REQ-035 Frame 0x07 with parity 0 (correct value is 1) -> Rx_PERROR=1, Rx_VALID stays low, Rx_DATA unchanged.
REQ-036 Frame 0x3C with stop bit 0 -> Rx_FERROR=1 and no Rx_VALID; a following frame 0x55 -> Rx_DATA=8'h55 and Rx_FERROR cleared.
REQ-037 Low glitch of 4 ticks on an idle line -> false start; FSM returns to IDLE, Rx_BUSY low by count 10, no output change.
REQ-038 Back-to-back frames 0x01 then 0xFE with the second start edge 7 ticks after the stop-bit midpoint -> two Rx_VALID pulses with the correct data.
REQ-039 Reset (or Rx_EN low) during data bit 4 of frame 0x99 -> no Rx_VALID; a following frame 0x42 is received correctly.
